// File: rtl/vgpr_wb_pkg.sv
// ============================================================================
// vgpr_wb_pkg : shared widths, queue-entry header type and round-robin helper
// Rev 1.0
// ============================================================================
`default_nettype none

package vgpr_wb_pkg;

    localparam int VGPR_ADDR_W = 10;
    localparam int WFID_W      = 6;
    localparam int LANE_W      = 32;

    // Control part of a queue entry; mask/data widths depend on LANES and travel alongside.
    typedef struct packed {
        logic                   wr_en;
        logic                   instr_done;
        logic [WFID_W-1:0]      wfid;
        logic [VGPR_ADDR_W-1:0] addr;
    } wb_hdr_t;

    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vgpr_wb_fifo.sv
// ============================================================================
// vgpr_wb_fifo : per-channel writeback queue; pushes while full are dropped
// Rev 1.0
// ============================================================================
`default_nettype none

module vgpr_wb_fifo
    import vgpr_wb_pkg::*;
#(
    parameter int LANES = 64,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  wb_hdr_t                   push_hdr,
    input  logic [LANES-1:0]          push_mask,
    input  logic [LANES*LANE_W-1:0]   push_data,
    input  logic                      pop,
    output logic                      ready,
    output logic                      empty,
    output logic                      drop,
    output wb_hdr_t                   head_hdr,
    output logic [LANES-1:0]          head_mask,
    output logic [LANES*LANE_W-1:0]   head_data
);

    localparam int AW = $clog2(DEPTH);

    wb_hdr_t                 hdr_mem  [DEPTH];
    logic [LANES-1:0]        mask_mem [DEPTH];
    logic [LANES*LANE_W-1:0] data_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // Readiness looks only at the stored count, so a pop never frees a slot in the same cycle.
    assign ready   = (count < (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ready;
    assign pop_ok  = pop & ~empty;
    assign drop    = push & ~ready;

    assign head_hdr  = hdr_mem[rd_ptr];
    assign head_mask = mask_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            hdr_mem[wr_ptr]  <= push_hdr;
            mask_mem[wr_ptr] <= push_mask;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/vgpr_wb_arbiter.sv
// ============================================================================
// vgpr_wb_arbiter : round-robin merge of ALU writeback channels onto one VGPR port
// Optional macro VGPR_WB_STATS_EN adds the stall_cycles counter.  Rev 1.0
// ============================================================================
`default_nettype none

module vgpr_wb_arbiter
    import vgpr_wb_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int LANES  = 64,
    parameter int DEPTH  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                ch_wr_en,
    input  logic [NUM_CH-1:0]                ch_instr_done,
    input  logic [NUM_CH*WFID_W-1:0]         ch_instr_done_wfid,
    input  logic [NUM_CH*VGPR_ADDR_W-1:0]    ch_dest_addr,
    input  logic [NUM_CH*LANES-1:0]          ch_wr_mask,
    input  logic [NUM_CH*LANES*LANE_W-1:0]   ch_dest_data,
    output logic [NUM_CH-1:0]                ch_ready,
    input  logic                             vgpr_wr_stall,
    output logic                             vgpr_wr_en,
    output logic [VGPR_ADDR_W-1:0]           vgpr_wr_addr,
    output logic [LANES-1:0]                 vgpr_wr_mask,
    output logic [LANES*LANE_W-1:0]          vgpr_wr_data,
    output logic                             issue_alu_wr_done,
    output logic [WFID_W-1:0]                issue_alu_wr_done_wfid,
    output logic [VGPR_ADDR_W-1:0]           issue_alu_dest_reg_addr,
    output logic                             issue_alu_dest_reg_valid,
    output logic [NUM_CH-1:0]                overflow_err
`ifdef VGPR_WB_STATS_EN
    ,
    output logic [15:0]                      stall_cycles
`endif
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    wb_hdr_t                 head_hdr  [NUM_CH];
    logic [LANES-1:0]        head_mask [NUM_CH];
    logic [LANES*LANE_W-1:0] head_data [NUM_CH];
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH-1:0]       pop;
    logic [NUM_CH-1:0]       drop;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_valid;
    int               cand;
    wb_hdr_t          sel_hdr;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            wb_hdr_t push_hdr;
            assign push_hdr = {ch_wr_en[i], ch_instr_done[i],
                               ch_instr_done_wfid[i*WFID_W +: WFID_W],
                               ch_dest_addr[i*VGPR_ADDR_W +: VGPR_ADDR_W]};

            vgpr_wb_fifo #(
                .LANES (LANES),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (ch_wr_en[i] | ch_instr_done[i]),
                .push_hdr  (push_hdr),
                .push_mask (ch_wr_mask[i*LANES +: LANES]),
                .push_data (ch_dest_data[i*LANES*LANE_W +: LANES*LANE_W]),
                .pop       (pop[i]),
                .ready     (ch_ready[i]),
                .empty     (empty[i]),
                .drop      (drop[i]),
                .head_hdr  (head_hdr[i]),
                .head_mask (head_mask[i]),
                .head_data (head_data[i])
            );
        end
    endgenerate

    // First non-empty channel found scanning upward from rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        pop         = '0;
        if (!vgpr_wr_stall) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cand = rr_index(int'(rr_ptr), k, NUM_CH);
                if (!grant_valid && !empty[PTR_W'(cand)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = PTR_W'(cand);
                end
            end
        end
        pop[grant_idx] = grant_valid;
    end

    assign sel_hdr = head_hdr[grant_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= PTR_W'(rr_index(int'(grant_idx), 1, NUM_CH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vgpr_wr_en               <= 1'b0;
            vgpr_wr_addr             <= '0;
            vgpr_wr_mask             <= '0;
            vgpr_wr_data             <= '0;
            issue_alu_wr_done        <= 1'b0;
            issue_alu_wr_done_wfid   <= '0;
            issue_alu_dest_reg_addr  <= '0;
            issue_alu_dest_reg_valid <= 1'b0;
        end else if (grant_valid) begin
            vgpr_wr_en               <= sel_hdr.wr_en;
            vgpr_wr_addr             <= sel_hdr.addr;
            vgpr_wr_mask             <= sel_hdr.wr_en ? head_mask[grant_idx] : '0;
            vgpr_wr_data             <= sel_hdr.wr_en ? head_data[grant_idx] : '0;
            issue_alu_wr_done        <= sel_hdr.instr_done;
            issue_alu_wr_done_wfid   <= sel_hdr.wfid;
            issue_alu_dest_reg_addr  <= sel_hdr.addr;
            issue_alu_dest_reg_valid <= sel_hdr.wr_en;
        end else begin
            vgpr_wr_en               <= 1'b0;
            vgpr_wr_addr             <= '0;
            vgpr_wr_mask             <= '0;
            vgpr_wr_data             <= '0;
            issue_alu_wr_done        <= 1'b0;
            issue_alu_wr_done_wfid   <= '0;
            issue_alu_dest_reg_addr  <= '0;
            issue_alu_dest_reg_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow_err <= '0;
        else     overflow_err <= overflow_err | drop;
    end

`ifdef VGPR_WB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (vgpr_wr_stall && (empty != '1) && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vgpr_wb_arbiter.sv
// ============================================================================
// tb_vgpr_wb_arbiter : directed self-checking bench for vgpr_wb_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vgpr_wb_arbiter;

    localparam int NUM_CH = 8;
    localparam int LANES  = 64;
    localparam int DEPTH  = 2;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_CH-1:0]             ch_wr_en;
    logic [NUM_CH-1:0]             ch_instr_done;
    logic [NUM_CH*6-1:0]           ch_instr_done_wfid;
    logic [NUM_CH*10-1:0]          ch_dest_addr;
    logic [NUM_CH*LANES-1:0]       ch_wr_mask;
    logic [NUM_CH*LANES*32-1:0]    ch_dest_data;
    logic [NUM_CH-1:0]             ch_ready;
    logic                          vgpr_wr_stall;
    logic                          vgpr_wr_en;
    logic [9:0]                    vgpr_wr_addr;
    logic [LANES-1:0]              vgpr_wr_mask;
    logic [LANES*32-1:0]           vgpr_wr_data;
    logic                          issue_alu_wr_done;
    logic [5:0]                    issue_alu_wr_done_wfid;
    logic [9:0]                    issue_alu_dest_reg_addr;
    logic                          issue_alu_dest_reg_valid;
    logic [NUM_CH-1:0]             overflow_err;
`ifdef VGPR_WB_STATS_EN
    logic [15:0]                   stall_cycles;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    vgpr_wb_arbiter #(
        .NUM_CH (NUM_CH),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .ch_wr_en                 (ch_wr_en),
        .ch_instr_done            (ch_instr_done),
        .ch_instr_done_wfid       (ch_instr_done_wfid),
        .ch_dest_addr             (ch_dest_addr),
        .ch_wr_mask               (ch_wr_mask),
        .ch_dest_data             (ch_dest_data),
        .ch_ready                 (ch_ready),
        .vgpr_wr_stall            (vgpr_wr_stall),
        .vgpr_wr_en               (vgpr_wr_en),
        .vgpr_wr_addr             (vgpr_wr_addr),
        .vgpr_wr_mask             (vgpr_wr_mask),
        .vgpr_wr_data             (vgpr_wr_data),
        .issue_alu_wr_done        (issue_alu_wr_done),
        .issue_alu_wr_done_wfid   (issue_alu_wr_done_wfid),
        .issue_alu_dest_reg_addr  (issue_alu_dest_reg_addr),
        .issue_alu_dest_reg_valid (issue_alu_dest_reg_valid),
        .overflow_err             (overflow_err)
`ifdef VGPR_WB_STATS_EN
        ,
        .stall_cycles             (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        ch_wr_en           = '0;
        ch_instr_done      = '0;
        ch_instr_done_wfid = '0;
        ch_dest_addr       = '0;
        ch_wr_mask         = '0;
        ch_dest_data       = '0;
    endtask

    task automatic load_ch(input int ch, input logic we, input logic done, input logic [5:0] wfid,
                           input logic [9:0] addr, input logic [63:0] mask, input logic [31:0] d0);
        ch_wr_en[ch]                      = we;
        ch_instr_done[ch]                 = done;
        ch_instr_done_wfid[ch*6 +: 6]     = wfid;
        ch_dest_addr[ch*10 +: 10]         = addr;
        ch_wr_mask[ch*LANES +: LANES]     = mask;
        ch_dest_data[ch*LANES*32 +: 32]   = d0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        vgpr_wr_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if ({vgpr_wr_en, issue_alu_wr_done, issue_alu_dest_reg_valid} !== 3'b000)
            $display("FAIL reset_strobes got=%b exp=000", {vgpr_wr_en, issue_alu_wr_done, issue_alu_dest_reg_valid});
        else pass_cnt++;
        total_cnt++;
        if (ch_ready !== 8'hFF) $display("FAIL reset_ready got=%h exp=ff", ch_ready);
        else pass_cnt++;
        total_cnt++;
        if (overflow_err !== 8'h00 || vgpr_wr_addr !== 10'd0 || vgpr_wr_mask !== 64'd0)
            $display("FAIL reset_zero got=%h/%h/%h exp=0/0/0", overflow_err, vgpr_wr_addr, vgpr_wr_mask);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        logic [LANES*32-1:0] exp_data;
        exp_data       = '0;
        exp_data[31:0] = 32'hffff0000;
        @(negedge clk);
        load_ch(2, 1'b1, 1'b0, 6'd0, 10'd50, 64'h1, 32'hffff0000);
        @(negedge clk);
        clear_inputs();
        total_cnt++;
        if (vgpr_wr_en !== 1'b0) $display("FAIL single_early got=%b exp=0", vgpr_wr_en);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (vgpr_wr_en !== 1'b1 || vgpr_wr_addr !== 10'd50 || vgpr_wr_mask !== 64'h1)
            $display("FAIL single_port got=%b/%0d/%h exp=1/50/1", vgpr_wr_en, vgpr_wr_addr, vgpr_wr_mask);
        else pass_cnt++;
        total_cnt++;
        if (vgpr_wr_data !== exp_data) $display("FAIL single_data got=%h exp=%h", vgpr_wr_data[63:0], exp_data[63:0]);
        else pass_cnt++;
        total_cnt++;
        if (issue_alu_dest_reg_valid !== 1'b1 || issue_alu_dest_reg_addr !== 10'd50 || issue_alu_wr_done !== 1'b0)
            $display("FAIL single_issue got=%b/%0d/%b exp=1/50/0", issue_alu_dest_reg_valid, issue_alu_dest_reg_addr, issue_alu_wr_done);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (vgpr_wr_en !== 1'b0 || vgpr_wr_data !== '0) $display("FAIL single_idle got=%b exp=0", vgpr_wr_en);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [9:0]  exp_addr [3] = '{10'd100, 10'd103, 10'd107};
        logic [63:0] exp_mask [3] = '{64'h1, 64'h8, 64'h80};
        do_reset();
        @(negedge clk);
        load_ch(0, 1'b1, 1'b0, 6'd0, 10'd100, 64'h1,  32'h0);
        load_ch(3, 1'b1, 1'b0, 6'd0, 10'd103, 64'h8,  32'h3);
        load_ch(7, 1'b1, 1'b0, 6'd0, 10'd107, 64'h80, 32'h7);
        @(negedge clk);
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (vgpr_wr_en !== 1'b1 || vgpr_wr_addr !== exp_addr[k] || vgpr_wr_mask !== exp_mask[k])
                $display("FAIL rr_order%0d got=%b/%0d/%h exp=1/%0d/%h", k, vgpr_wr_en, vgpr_wr_addr, vgpr_wr_mask, exp_addr[k], exp_mask[k]);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        total_cnt++;
        if (vgpr_wr_en !== 1'b0) $display("FAIL rr_idle got=%b exp=0", vgpr_wr_en);
        else pass_cnt++;
    endtask

    task automatic test_done_only();
        @(negedge clk);
        load_ch(5, 1'b0, 1'b1, 6'd17, 10'd33, 64'hFF, 32'hdeadbeef);
        @(negedge clk);
        clear_inputs();
        @(posedge clk); #1;
        total_cnt++;
        if (issue_alu_wr_done !== 1'b1 || issue_alu_wr_done_wfid !== 6'd17)
            $display("FAIL done_flag got=%b/%0d exp=1/17", issue_alu_wr_done, issue_alu_wr_done_wfid);
        else pass_cnt++;
        total_cnt++;
        if (vgpr_wr_en !== 1'b0 || issue_alu_dest_reg_valid !== 1'b0 || vgpr_wr_mask !== 64'd0 || vgpr_wr_data !== '0)
            $display("FAIL done_nowrite got=%b/%b/%h/%h exp=0/0/0/0", vgpr_wr_en, issue_alu_dest_reg_valid, vgpr_wr_mask, vgpr_wr_data[63:0]);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (issue_alu_wr_done !== 1'b0) $display("FAIL done_idle got=%b exp=0", issue_alu_wr_done);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        @(negedge clk);
        vgpr_wr_stall = 1'b1;
        load_ch(1, 1'b1, 1'b0, 6'd0, 10'd11, 64'h1, 32'h11);
        @(negedge clk);
        total_cnt++;
        if (ch_ready[1] !== 1'b1) $display("FAIL ovf_ready1 got=%b exp=1", ch_ready[1]);
        else pass_cnt++;
        load_ch(1, 1'b1, 1'b0, 6'd0, 10'd12, 64'h2, 32'h12);
        @(negedge clk);
        total_cnt++;
        if (ch_ready[1] !== 1'b0 || overflow_err !== 8'h00)
            $display("FAIL ovf_full got=%b/%h exp=0/00", ch_ready[1], overflow_err);
        else pass_cnt++;
        load_ch(1, 1'b1, 1'b0, 6'd0, 10'd13, 64'h4, 32'h13);
        @(negedge clk);
        clear_inputs();
        total_cnt++;
        if (overflow_err !== 8'h02) $display("FAIL ovf_flag got=%h exp=02", overflow_err);
        else pass_cnt++;
        total_cnt++;
        if (vgpr_wr_en !== 1'b0 || issue_alu_wr_done !== 1'b0) $display("FAIL ovf_stalled got=%b exp=0", vgpr_wr_en);
        else pass_cnt++;
        vgpr_wr_stall = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (vgpr_wr_en !== 1'b1 || vgpr_wr_addr !== 10'd11) $display("FAIL ovf_first got=%b/%0d exp=1/11", vgpr_wr_en, vgpr_wr_addr);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (vgpr_wr_en !== 1'b1 || vgpr_wr_addr !== 10'd12) $display("FAIL ovf_second got=%b/%0d exp=1/12", vgpr_wr_en, vgpr_wr_addr);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (vgpr_wr_en !== 1'b0) $display("FAIL ovf_third got=%b/%0d exp=0", vgpr_wr_en, vgpr_wr_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ch_ready[1] !== 1'b1 || overflow_err !== 8'h02)
            $display("FAIL ovf_sticky got=%b/%h exp=1/02", ch_ready[1], overflow_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                total_cnt++;
                if (vgpr_wr_en !== 1'b1 || vgpr_wr_addr !== 10'(200 + k - 2))
                    $display("FAIL b2b_out%0d got=%b/%0d exp=1/%0d", k, vgpr_wr_en, vgpr_wr_addr, 200 + k - 2);
                else pass_cnt++;
            end
            if (k >= 1 && k <= 4) begin
                total_cnt++;
                if (ch_ready[3] !== 1'b1) $display("FAIL b2b_ready%0d got=%b exp=1", k, ch_ready[3]);
                else pass_cnt++;
            end
            if (k < 4) load_ch(3, 1'b1, 1'b0, 6'd0, 10'(200 + k), 64'h1, 32'(k));
            else       clear_inputs();
        end
        @(negedge clk);
        total_cnt++;
        if (vgpr_wr_en !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", vgpr_wr_en);
        else pass_cnt++;
    endtask

    task automatic test_reset_discard();
        @(negedge clk);
        vgpr_wr_stall = 1'b1;
        load_ch(0, 1'b1, 1'b0, 6'd0, 10'd300, 64'h1, 32'h1);
        load_ch(2, 1'b1, 1'b1, 6'd2, 10'd302, 64'h1, 32'h2);
        load_ch(4, 1'b0, 1'b1, 6'd4, 10'd304, 64'h1, 32'h4);
        load_ch(6, 1'b1, 1'b0, 6'd0, 10'd306, 64'h1, 32'h6);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({vgpr_wr_en, issue_alu_wr_done, issue_alu_dest_reg_valid} !== 3'b000 || vgpr_wr_addr !== 10'd0)
            $display("FAIL rstq_outputs got=%b exp=000", {vgpr_wr_en, issue_alu_wr_done, issue_alu_dest_reg_valid});
        else pass_cnt++;
        total_cnt++;
        if (ch_ready !== 8'hFF || overflow_err !== 8'h00)
            $display("FAIL rstq_ready got=%h/%h exp=ff/00", ch_ready, overflow_err);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        vgpr_wr_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (vgpr_wr_en !== 1'b0 || issue_alu_wr_done !== 1'b0)
                $display("FAIL rstq_emit%0d got=%b/%b exp=0/0", k, vgpr_wr_en, issue_alu_wr_done);
            else pass_cnt++;
        end
    endtask

`ifdef VGPR_WB_STATS_EN
    task automatic test_stats();
        do_reset();
        @(negedge clk);
        vgpr_wr_stall = 1'b1;
        load_ch(4, 1'b1, 1'b0, 6'd0, 10'd44, 64'h1, 32'h4);
        @(negedge clk);
        clear_inputs();
        repeat (10) @(negedge clk);
        total_cnt++;
        if (stall_cycles !== 16'd10) $display("FAIL stats_count got=%0d exp=10", stall_cycles);
        else pass_cnt++;
        vgpr_wr_stall = 1'b0;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        vgpr_wr_stall = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        test_reset();
        test_single_write();
        test_round_robin();
        test_done_only();
        test_overflow();
        test_back_to_back();
        test_reset_discard();
`ifdef VGPR_WB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
